// File: rtl/branch_predict_unit_if.sv
// Fetch/EX-side signal bundle for the branch predictor: lookup, resolve and redirect.
interface branch_predict_unit_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  f_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_branch;
    logic             ex_jal;
    logic             ex_jalr;
    logic             ex_cond;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_rs1;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_target;
    logic             halt_com;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output f_pc, ex_valid, ex_pc, ex_branch, ex_jal, ex_jalr, ex_cond,
               ex_imm, ex_rs1, ex_pred_taken, ex_pred_target, halt_com,
        input  pred_taken, pred_target, redirect, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_branch, ex_jal, ex_jalr, ex_cond,
               ex_imm, ex_rs1, ex_pred_taken, ex_pred_target, halt_com,
        output pred_taken, pred_target, redirect, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup,
// EX-stage resolution with same-cycle redirect, saturating mispredict counter.
module branch_predict_unit #(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predict_unit_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0]            tbl_valid;
    logic [ENTRIES-1:0][1:0]       tbl_cnt;
    logic [ENTRIES-1:0][TAG_W-1:0] tbl_tag;
    logic [ENTRIES-1:0][PC_W-1:0]  tbl_tgt;

    // Fetch lookup sees only registered state, so a same-cycle update is not bypassed.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [PC_W-1:0]  f_seq;

    assign f_idx           = bus.f_pc[IDX_W+1:2];
    assign f_tag           = bus.f_pc[PC_W-1:IDX_W+2];
    assign f_seq           = bus.f_pc + PC_W'(4);
    assign f_hit           = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
    assign bus.pred_taken  = f_hit & tbl_cnt[f_idx][1];
    assign bus.pred_target = bus.pred_taken ? tbl_tgt[f_idx] : f_seq;

    logic [31:0]      ex_pc32, br_tgt, jalr_tgt, seq_pc, actual_target;
    logic             is_jump, actual_taken, mispredict, upd, ex_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic [PC_W-1:0]  ex_tgt;

    assign ex_pc32       = 32'(bus.ex_pc);
    assign br_tgt        = ex_pc32 + bus.ex_imm;
    assign jalr_tgt      = (bus.ex_rs1 + bus.ex_imm) & ~32'd1;
    assign seq_pc        = ex_pc32 + 32'd4;
    assign is_jump       = bus.ex_jal | bus.ex_jalr;
    assign actual_taken  = is_jump | (bus.ex_branch & bus.ex_cond);
    assign actual_target = bus.ex_jalr ? jalr_tgt : (actual_taken ? br_tgt : seq_pc);
    assign ex_tgt        = actual_target[PC_W-1:0];

    assign mispredict = bus.ex_valid & ~bus.halt_com &
                        ((bus.ex_pred_taken != actual_taken) |
                         (actual_taken & (bus.ex_pred_target != ex_tgt)));

    always_comb begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = seq_pc;
        if (bus.halt_com) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = ex_pc32;
        end else if (mispredict) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = actual_target;
        end
    end

    assign upd    = bus.ex_valid & ~bus.halt_com & (bus.ex_branch | is_jump);
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[PC_W-1:IDX_W+2];
    assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic             v_q;
        logic [1:0]       c_q;
        logic [TAG_W-1:0] t_q;
        logic [PC_W-1:0]  g_q;
        logic             wr;

        assign wr = upd && (ex_idx == IDX_W'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 2'd1;
                t_q <= '0;
                g_q <= '0;
            end else if (wr) begin
                if (ex_hit) begin
                    if (actual_taken) begin
                        c_q <= (c_q == 2'd3) ? 2'd3 : c_q + 2'd1;
                        g_q <= ex_tgt;
                    end else begin
                        c_q <= (c_q == 2'd0) ? 2'd0 : c_q - 2'd1;
                    end
                end else if (actual_taken) begin
                    // Unconditional jumps allocate strongly taken, branches weakly taken.
                    v_q <= 1'b1;
                    t_q <= ex_tag;
                    g_q <= ex_tgt;
                    c_q <= is_jump ? 2'd3 : 2'd2;
                end
            end
        end

        assign tbl_valid[i] = v_q;
        assign tbl_cnt[i]   = c_q;
        assign tbl_tag[i]   = t_q;
        assign tbl_tgt[i]   = g_q;
    end

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (mispredict && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: one task per scenario, hand-computed expectations.
module tb_branch_predict_unit;
    localparam int PC_W  = 9;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    branch_predict_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ex_idle();
        bus.ex_valid       = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_branch      = 1'b0;
        bus.ex_jal         = 1'b0;
        bus.ex_jalr        = 1'b0;
        bus.ex_cond        = 1'b0;
        bus.ex_imm         = '0;
        bus.ex_rs1         = '0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = '0;
        bus.halt_com       = 1'b0;
    endtask

    task automatic set_branch(input logic [PC_W-1:0] pc, input logic [31:0] imm,
                              input logic cond, input logic pt, input logic [PC_W-1:0] ptgt);
        ex_idle();
        bus.ex_valid       = 1'b1;
        bus.ex_branch      = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.ex_cond        = cond;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ex_idle();
        bus.f_pc = 9'h040;
        #3;
        n_tests++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %0h want 0", bus.pred_taken); end
        n_tests++; if (bus.pred_target !== 9'h044) begin n_fail++; $display("FAIL reset_pred_target got %0h want 044", bus.pred_target); end
        n_tests++; if (bus.mispredict_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got %0h want 0", bus.mispredict_cnt); end
        n_tests++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h4) begin n_fail++; $display("FAIL reset_redirect got %0h/%0h want 0/4", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_branch_taken();
        bus.f_pc = 9'h040;
        set_branch(9'h040, 32'h20, 1'b1, 1'b0, 9'h000);
        #1;
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h060) begin n_fail++; $display("FAIL bt_redirect got %0h/%0h want 1/60", bus.redirect, bus.redirect_pc); end
        n_tests++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL bt_no_bypass got %0h want 0", bus.pred_taken); end
        @(negedge clk);
        ex_idle();
        #1;
        n_tests++; if (bus.mispredict_cnt !== 8'd1) begin n_fail++; $display("FAIL bt_cnt got %0d want 1", bus.mispredict_cnt); end
        n_tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 9'h060) begin n_fail++; $display("FAIL bt_lookup got %0h/%0h want 1/60", bus.pred_taken, bus.pred_target); end
    endtask

    task automatic test_not_taken();
        @(negedge clk);
        bus.f_pc = 9'h040;
        set_branch(9'h040, 32'h20, 1'b0, 1'b1, 9'h060);
        #1;
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h044) begin n_fail++; $display("FAIL nt1_redirect got %0h/%0h want 1/44", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        set_branch(9'h040, 32'h20, 1'b0, 1'b0, 9'h000);
        #1;
        n_tests++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt1_lookup got %0h want 0", bus.pred_taken); end
        n_tests++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h044) begin n_fail++; $display("FAIL nt2_redirect got %0h/%0h want 0/44", bus.redirect, bus.redirect_pc); end
        n_tests++; if (bus.mispredict_cnt !== 8'd2) begin n_fail++; $display("FAIL nt1_cnt got %0d want 2", bus.mispredict_cnt); end
        @(negedge clk);
        ex_idle();
        #1;
        n_tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 9'h044) begin n_fail++; $display("FAIL nt2_lookup got %0h/%0h want 0/44", bus.pred_taken, bus.pred_target); end
        n_tests++; if (bus.mispredict_cnt !== 8'd2) begin n_fail++; $display("FAIL nt2_cnt got %0d want 2", bus.mispredict_cnt); end
    endtask

    task automatic test_jalr();
        @(negedge clk);
        bus.f_pc = 9'h084;
        ex_idle();
        bus.ex_valid       = 1'b1;
        bus.ex_jalr        = 1'b1;
        bus.ex_pc          = 9'h084;
        bus.ex_rs1         = 32'h105;
        bus.ex_imm         = 32'h4;
        bus.ex_pred_taken  = 1'b1;
        bus.ex_pred_target = 9'h108;
        #1;
        n_tests++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h088) begin n_fail++; $display("FAIL jalr_redirect got %0h/%0h want 0/88", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        // A not-taken branch at the same PC only drops a strongly-taken entry to weakly taken.
        set_branch(9'h084, 32'h4, 1'b0, 1'b1, 9'h108);
        #1;
        n_tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 9'h108) begin n_fail++; $display("FAIL jalr_alloc got %0h/%0h want 1/108", bus.pred_taken, bus.pred_target); end
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h088) begin n_fail++; $display("FAIL jalr_nt_redirect got %0h/%0h want 1/88", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        ex_idle();
        #1;
        n_tests++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL jalr_cnt3 got %0h want 1", bus.pred_taken); end
        n_tests++; if (bus.mispredict_cnt !== 8'd3) begin n_fail++; $display("FAIL jalr_cnt got %0d want 3", bus.mispredict_cnt); end
    endtask

    task automatic test_halt();
        @(negedge clk);
        bus.f_pc = 9'h0A0;
        set_branch(9'h0A0, 32'h20, 1'b1, 1'b0, 9'h000);
        bus.halt_com = 1'b1;
        #1;
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0A0) begin n_fail++; $display("FAIL halt_redirect got %0h/%0h want 1/a0", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        bus.ex_valid = 1'b0;
        #1;
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0A0) begin n_fail++; $display("FAIL halt_novalid got %0h/%0h want 1/a0", bus.redirect, bus.redirect_pc); end
        n_tests++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL halt_no_alloc got %0h want 0", bus.pred_taken); end
        n_tests++; if (bus.mispredict_cnt !== 8'd3) begin n_fail++; $display("FAIL halt_cnt got %0d want 3", bus.mispredict_cnt); end
        @(negedge clk);
        ex_idle();
    endtask

    task automatic test_jal();
        bus.f_pc = 9'h0C0;
        ex_idle();
        bus.ex_valid = 1'b1;
        bus.ex_jal   = 1'b1;
        bus.ex_pc    = 9'h0C0;
        bus.ex_imm   = 32'hFFFF_FFC0;
        #1;
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h080) begin n_fail++; $display("FAIL jal_redirect got %0h/%0h want 1/80", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        bus.ex_pred_taken  = 1'b1;
        bus.ex_pred_target = 9'h090;
        #1;
        n_tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 9'h080) begin n_fail++; $display("FAIL jal_lookup got %0h/%0h want 1/80", bus.pred_taken, bus.pred_target); end
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h080) begin n_fail++; $display("FAIL jal_tgt_miss got %0h/%0h want 1/80", bus.redirect, bus.redirect_pc); end
        @(negedge clk);
        bus.ex_valid = 1'b0;
        #1;
        n_tests++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0C4) begin n_fail++; $display("FAIL bubble_redirect got %0h/%0h want 0/c4", bus.redirect, bus.redirect_pc); end
        n_tests++; if (bus.mispredict_cnt !== 8'd5) begin n_fail++; $display("FAIL jal_cnt got %0d want 5", bus.mispredict_cnt); end
        @(negedge clk);
        ex_idle();
        #1;
        n_tests++; if (bus.mispredict_cnt !== 8'd5) begin n_fail++; $display("FAIL bubble_cnt got %0d want 5", bus.mispredict_cnt); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        bus.f_pc = 9'h100;
        set_branch(9'h100, 32'h10, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < (1 << CNT_W) + 2; i++) @(negedge clk);
        #1;
        n_tests++; if (bus.mispredict_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt got %0h want ff", bus.mispredict_cnt); end
        n_tests++; if (bus.pred_taken !== 1'b1 || bus.pred_target !== 9'h110) begin n_fail++; $display("FAIL sat_lookup got %0h/%0h want 1/110", bus.pred_taken, bus.pred_target); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.mispredict_cnt !== 8'h00) begin n_fail++; $display("FAIL async_cnt got %0h want 0", bus.mispredict_cnt); end
        n_tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 9'h104) begin n_fail++; $display("FAIL async_lookup got %0h/%0h want 0/104", bus.pred_taken, bus.pred_target); end
        n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h110) begin n_fail++; $display("FAIL rst_redirect got %0h/%0h want 1/110", bus.redirect, bus.redirect_pc); end
        bus.f_pc = 9'h0C0;
        #1;
        n_tests++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_clear_jal got %0h want 0", bus.pred_taken); end
        @(negedge clk);
        bus.f_pc = 9'h100;
        #1;
        n_tests++; if (bus.mispredict_cnt !== 8'h00 || bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_hold got %0h/%0h want 0/0", bus.mispredict_cnt, bus.pred_taken); end
        @(negedge clk);
        rst_n = 1'b1;
        ex_idle();
        @(negedge clk);
        #1;
        n_tests++; if (bus.pred_taken !== 1'b0 || bus.mispredict_cnt !== 8'h00) begin n_fail++; $display("FAIL post_rst got %0h/%0h want 0/0", bus.pred_taken, bus.mispredict_cnt); end
        bus.f_pc = 9'h0C0;
        #1;
        n_tests++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 9'h0C4) begin n_fail++; $display("FAIL post_rst_stale got %0h/%0h want 0/c4", bus.pred_taken, bus.pred_target); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_branch_taken();
        test_not_taken();
        test_jalr();
        test_halt();
        test_jal();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter: PC_W, default 9, width of the instruction-memory PC.
REQ-002 Parameter: IDX_W, default 4, log2 of table entries; IDX_W+2 < PC_W.
REQ-003 Parameter: CNT_W, default 16, width of the mispredict counter.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 f_pc  in  PC_W  fetch-stage PC to predict.
REQ-008 pred_taken  out  1  fetch prediction: redirect fetch to pred_target.
REQ-009 pred_target  out  PC_W  predicted target; f_pc+4 when pred_taken=0.
REQ-010 ex_valid  in  1  EX-stage instruction is valid (not a bubble).
REQ-011 ex_pc  in  PC_W  PC of the EX-stage instruction.
REQ-012 ex_branch  in  1  conditional branch; ex_jal  in  1  jal; ex_jalr  in  1  jalr.
REQ-013 ex_cond  in  1  ALU branch condition (AluResult[0]).
REQ-014 ex_imm  in  32  sign-extended immediate; ex_rs1  in  32  rs1 value.
REQ-015 ex_pred_taken  in  1, ex_pred_target  in  PC_W  prediction piped along with the instruction.
REQ-016 halt_com  in  1  halt command from EX.
REQ-017 redirect  out  1  flush and load redirect_pc into PC.
REQ-018 redirect_pc  out  32  corrected fetch address.
REQ-019 mispredict_cnt  out  CNT_W  saturating count of redirects due to misprediction.

Function
REQ-020 Tables: 2^IDX_W entries, each holding valid, tag = pc[PC_W-1:IDX_W+2], target[PC_W-1:0], 2-bit counter; index = pc[IDX_W+1:2].
REQ-021 Lookup is combinational from f_pc: hit = valid & tag match; pred_taken = hit & counter[1]; pred_target = entry target if pred_taken, else f_pc+4 truncated to PC_W.
REQ-022 Arithmetic is 32-bit with ex_pc zero-extended: br_tgt = ex_pc+ex_imm; jalr_tgt = (ex_rs1+ex_imm) with bit 0 cleared; seq = ex_pc+4.
REQ-023 actual_taken = ex_jal | ex_jalr | (ex_branch & ex_cond); actual_target = jalr_tgt if ex_jalr, br_tgt if taken otherwise, else seq.
REQ-024 mispredict = ex_valid & ~halt_com & (ex_pred_taken != actual_taken | (actual_taken & ex_pred_target != actual_target[PC_W-1:0])).
REQ-025 redirect/redirect_pc are combinational in the same cycle: halt_com -> 1, ex_pc zero-extended (highest priority, overrides ex_valid); else mispredict -> 1, actual_target; else 0, seq.
REQ-026 Updates occur only when ex_valid=1, halt_com=0 and (ex_branch|ex_jal|ex_jalr); they take effect at the next rising edge.
REQ-027 Hit update: counter +1 saturating at 3 if actual_taken, else -1 saturating at 0; target <= actual_target[PC_W-1:0] if actual_taken.
REQ-028 Miss and actual_taken: allocate (overwrite) entry: valid=1, tag, target; counter=2 for branches, 3 for jal/jalr.
REQ-029 Miss and not taken: no table change.
REQ-030 Same-index lookup and update in one cycle: lookup returns the pre-edge value (no bypass).
REQ-031 mispredict_cnt increments by 1 on each clock with mispredict=1; holds at all-ones.
REQ-032 More than one of ex_branch/ex_jal/ex_jalr high is illegal; priority jalr > jal > branch.

Reset
REQ-033 rst_n=0 immediately clears every valid bit, sets every counter to 1 (weakly not-taken) and sets mispredict_cnt to 0, regardless of clk.
REQ-034 During reset pred_taken=0, pred_target=f_pc+4; redirect follows REQ-025 combinationally; no table update occurs on edges while rst_n=0.
REQ-035 Reset deassertion mid-operation resumes with empty tables; no stale entries are visible.

Verification
REQ-036 After reset, f_pc=0x040 -> pred_taken=0, pred_target=0x044; mispredict_cnt=0.
REQ-037 ex_branch=1, ex_pc=0x040, ex_imm=0x20, ex_cond=1, ex_pred_taken=0 -> redirect=1, redirect_pc=0x060, mispredict_cnt=1; next cycle f_pc=0x040 -> pred_taken=1, pred_target=0x060.
REQ-038 Same branch resolved not-taken twice with prediction matching internal state -> counter 2->1->0; f_pc=0x040 then gives pred_taken=0; redirects on first (mispredict, redirect_pc=0x044) only.
REQ-039 ex_jalr=1, ex_rs1=0x105, ex_imm=0x4, ex_pred_taken=1, ex_pred_target=0x108 -> redirect=0 (target 0x108 matches), entry counter=3.
REQ-040 halt_com=1 with ex_pc=0x0A0 and a concurrent mispredicting branch -> redirect=1, redirect_pc=0x0A0, no table update, mispredict_cnt unchanged.
REQ-041 Force mispredict on 2^CNT_W+2 consecutive cycles -> mispredict_cnt holds at all-ones; assert rst_n=0 mid-sequence -> cnt=0 and tables cleared without a clock edge.
